// File: rtl/color_conv_pkg.sv
// Shared types and sizing helpers for the frame-synchronous colour-conversion scheduler.
package color_conv_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACTIVE,
        DRAIN
    } sched_state_t;

    localparam int unsigned H_ACTIVE_DEFAULT = 640;
    localparam int unsigned V_ACTIVE_DEFAULT = 480;
    localparam int unsigned X_CNT_W          = $clog2(H_ACTIVE_DEFAULT);
    localparam int unsigned Y_CNT_W          = $clog2(V_ACTIVE_DEFAULT);
    localparam int unsigned FRAME_CNT_W      = 16;

    // Counter width that never collapses to zero bits for tiny parameter values.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/color_conv_sched_sideband_delay.sv
// Fixed-depth delay line for the {sof, eol} sideband pair, matching converter latency.
module sideband_delay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] d_i,
    output logic [1:0] q_o
);

    logic [1:0] pipe_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/color_conv_sched.sv
// Applies conversion-mode requests on frame boundaries, stalling upstream while the converter
// drains, and aligns SOF/EOL sideband to the active conversion latency.
module color_conv_sched
    import color_conv_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEFAULT,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEFAULT,
    parameter int unsigned CONV_LATENCY = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   cfg_conv_en_i,
    input  logic                   cfg_update_i,
    input  logic                   pix_vld_i,
    input  logic                   pix_sof_i,
    output logic                   pix_rdy_o,
    output logic                   conv_en_o,
    output logic                   pix_sof_o,
    output logic                   pix_eol_o,
    output logic                   pending_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic                   sync_err_o
);

    localparam int unsigned XW = cnt_w(H_ACTIVE);
    localparam int unsigned YW = cnt_w(V_ACTIVE);
    localparam int unsigned DW = cnt_w(CONV_LATENCY);

    sched_state_t           state_q, state_d;
    logic [XW-1:0]          x_q, x_d, x_eff;
    logic [YW-1:0]          y_q, y_d, y_eff;
    logic [DW-1:0]          drain_q, drain_d;
    logic                   conv_en_q, conv_en_d;
    logic                   req_q, req_d;
    logic                   pending_q, pending_d;
    logic                   rdy_q, rdy_d;
    logic                   err_q, err_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;

    logic       accept, sof_acc, counted, eol, eof, resync;
    logic [1:0] sb_dly;

    assign accept  = pix_vld_i & rdy_q;
    assign sof_acc = accept & pix_sof_i;
    // Outside a frame only a SOF pixel is counted; it always lands at (0,0).
    assign counted = accept & ((state_q != WAIT_SOF) | pix_sof_i);
    assign x_eff   = pix_sof_i ? '0 : x_q;
    assign y_eff   = pix_sof_i ? '0 : y_q;
    assign eol     = counted & (x_eff == XW'(H_ACTIVE - 1));
    assign eof     = eol & (y_eff == YW'(V_ACTIVE - 1));
    assign resync  = sof_acc & (state_q == ACTIVE) & ((x_q != '0) | (y_q != '0));

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        drain_d   = drain_q;
        conv_en_d = conv_en_q;
        req_d     = req_q;
        pending_d = pending_q;
        rdy_d     = rdy_q;
        frame_d   = frame_q;
        err_d     = err_q;

        if (counted) begin
            if (eol) begin
                x_d = '0;
                y_d = eof ? '0 : y_eff + YW'(1);
            end else begin
                x_d = x_eff + XW'(1);
                y_d = y_eff;
            end
        end

        if (cfg_update_i) begin
            req_d     = cfg_conv_en_i;
            pending_d = 1'b1;
            err_d     = 1'b0;
        end
        if (resync) begin
            err_d = 1'b1;
        end

        case (state_q)
            WAIT_SOF: begin
                if (pending_q) begin
                    conv_en_d = req_q;
                    if (!cfg_update_i) begin
                        pending_d = 1'b0;
                    end
                end
                if (sof_acc) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (eof) begin
                    frame_d = frame_q + FRAME_CNT_W'(1);
                    if (pending_q) begin
                        state_d = DRAIN;
                        rdy_d   = 1'b0;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                // req_d already reflects an update landing in this very cycle.
                if (drain_q == DW'(CONV_LATENCY - 1)) begin
                    conv_en_d = req_d;
                    pending_d = 1'b0;
                    rdy_d     = 1'b1;
                    state_d   = ACTIVE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= WAIT_SOF;
            x_q       <= '0;
            y_q       <= '0;
            drain_q   <= '0;
            conv_en_q <= 1'b0;
            req_q     <= 1'b0;
            pending_q <= 1'b0;
            rdy_q     <= 1'b1;
            frame_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            drain_q   <= drain_d;
            conv_en_q <= conv_en_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            rdy_q     <= rdy_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
        end
    end

    sideband_delay #(
        .DEPTH (CONV_LATENCY)
    ) u_sideband_delay (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     ({sof_acc, eol}),
        .q_o     (sb_dly)
    );

    assign pix_sof_o   = conv_en_q ? sb_dly[1] : sof_acc;
    assign pix_eol_o   = conv_en_q ? sb_dly[0] : eol;
    assign pix_rdy_o   = rdy_q;
    assign conv_en_o   = conv_en_q;
    assign pending_o   = pending_q;
    assign frame_cnt_o = frame_q;
    assign sync_err_o  = err_q;

endmodule

// File: tb/tb_color_conv_sched.sv
// Bench for color_conv_sched: two instances (latency 1 and 3) against a frame-level reference model.
module tb_color_conv_sched;

    localparam int H = 4;
    localparam int V = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_en, cfg_up;
    logic        vld [2];
    logic        sof [2];
    logic        rdy [2];
    logic        conv [2];
    logic        sof_o [2];
    logic        eol_o [2];
    logic        pend [2];
    logic        err [2];
    logic [15:0] fcnt [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position is a linear pixel index within the frame.
    bit          m_conv [2];
    bit          m_pend [2];
    bit          m_req [2];
    bit          m_sync [2];
    bit          m_err [2];
    int          m_idx [2];
    int          m_stall [2];
    int unsigned m_frames [2];
    bit [1:0]    m_dly [2][4];

    always #5 clk = ~clk;

    color_conv_sched #(
        .H_ACTIVE     (H),
        .V_ACTIVE     (V),
        .CONV_LATENCY (1)
    ) u_dut_lat1 (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .cfg_conv_en_i (cfg_en),
        .cfg_update_i  (cfg_up),
        .pix_vld_i     (vld[0]),
        .pix_sof_i     (sof[0]),
        .pix_rdy_o     (rdy[0]),
        .conv_en_o     (conv[0]),
        .pix_sof_o     (sof_o[0]),
        .pix_eol_o     (eol_o[0]),
        .pending_o     (pend[0]),
        .frame_cnt_o   (fcnt[0]),
        .sync_err_o    (err[0])
    );

    color_conv_sched #(
        .H_ACTIVE     (H),
        .V_ACTIVE     (V),
        .CONV_LATENCY (3)
    ) u_dut_lat3 (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .cfg_conv_en_i (cfg_en),
        .cfg_update_i  (cfg_up),
        .pix_vld_i     (vld[1]),
        .pix_sof_i     (sof[1]),
        .pix_rdy_o     (rdy[1]),
        .conv_en_o     (conv[1]),
        .pix_sof_o     (sof_o[1]),
        .pix_eol_o     (eol_o[1]),
        .pending_o     (pend[1]),
        .frame_cnt_o   (fcnt[1]),
        .sync_err_o    (err[1])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_conv[i]   = 1'b0;
            m_pend[i]   = 1'b0;
            m_req[i]    = 1'b0;
            m_sync[i]   = 1'b0;
            m_err[i]    = 1'b0;
            m_idx[i]    = 0;
            m_stall[i]  = 0;
            m_frames[i] = 0;
            for (int k = 0; k < 4; k++) m_dly[i][k] = 2'b00;
        end
    endtask

    task automatic classify(input int i, output bit cnt, output bit sacc, output bit eol,
                            output int p);
        bit acc;
        acc  = vld[i] && (m_stall[i] == 0);
        sacc = acc && sof[i];
        cnt  = acc && (m_sync[i] || sof[i]);
        p    = sof[i] ? 0 : m_idx[i];
        eol  = cnt && ((p % H) == H - 1);
    endtask

    task automatic model_check(input int i);
        bit cnt, sacc, eol;
        int p;
        bit [1:0] pr;
        classify(i, cnt, sacc, eol, p);
        pr = m_conv[i] ? m_dly[i][lat_of(i)-1] : {sacc, eol};
        check_eq($sformatf("rdy%0d", i), rdy[i], m_stall[i] == 0);
        check_eq($sformatf("conv_en%0d", i), conv[i], m_conv[i]);
        check_eq($sformatf("pending%0d", i), pend[i], m_pend[i]);
        check_eq($sformatf("frame_cnt%0d", i), fcnt[i], m_frames[i]);
        check_eq($sformatf("sync_err%0d", i), err[i], m_err[i]);
        check_eq($sformatf("sof_out%0d", i), sof_o[i], pr[1]);
        check_eq($sformatf("eol_out%0d", i), eol_o[i], pr[0]);
    endtask

    task automatic model_step(input int i);
        bit cnt, sacc, eol, eof, was_sync, old_pend, err_new;
        int p, st;
        classify(i, cnt, sacc, eol, p);
        was_sync = m_sync[i];
        old_pend = m_pend[i];
        eof      = cnt && (p == H * V - 1);
        err_new  = sacc && was_sync && (m_idx[i] != 0);
        for (int k = 3; k > 0; k--) m_dly[i][k] = m_dly[i][k-1];
        m_dly[i][0] = {sacc, eol};
        if (cnt) begin
            m_idx[i]  = eof ? 0 : p + 1;
            m_sync[i] = 1'b1;
        end
        if (eof) m_frames[i] = (m_frames[i] + 1) % 65536;
        // Between frames a pending request takes effect at once.
        if (!was_sync && old_pend) m_conv[i] = m_req[i];
        if (cfg_up) begin
            m_req[i]  = cfg_en;
            m_pend[i] = 1'b1;
            m_err[i]  = 1'b0;
        end else if (!was_sync && old_pend) begin
            m_pend[i] = 1'b0;
        end
        if (err_new) m_err[i] = 1'b1;
        st = m_stall[i];
        if (st > 0) begin
            st--;
            if (st == 0) begin
                m_conv[i] = m_req[i];
                m_pend[i] = 1'b0;
            end
        end
        if (eof && old_pend) st = lat_of(i);
        m_stall[i] = st;
    endtask

    task automatic cycle();
        #1;
        for (int i = 0; i < 2; i++) model_check(i);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) model_step(i);
        end else begin
            model_reset();
        end
        @(negedge clk);
    endtask

    task automatic set_in(input bit v, input bit s, input bit up, input bit en);
        for (int i = 0; i < 2; i++) begin
            vld[i] = v;
            sof[i] = s;
        end
        cfg_up = up;
        cfg_en = en;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("%s_rdy%0d", tag, i), rdy[i], 1'b1);
            check_eq($sformatf("%s_conv%0d", tag, i), conv[i], 1'b0);
            check_eq($sformatf("%s_pend%0d", tag, i), pend[i], 1'b0);
            check_eq($sformatf("%s_fcnt%0d", tag, i), fcnt[i], 16'd0);
            check_eq($sformatf("%s_err%0d", tag, i), err[i], 1'b0);
            check_eq($sformatf("%s_eol%0d", tag, i), eol_o[i], 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        apply_reset();
        check_reset_values("reset");

        // Frame 1, bypass mode; request enable mid-frame at pixel 3.
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, k == 0, k == 3, 1'b1);
            #1;
            if (k == 3) begin
                check_eq("eol_pass0", eol_o[0], 1'b1);
                check_eq("eol_pass1", eol_o[1], 1'b1);
            end
            if (k == 7) begin
                check_eq("hold_conv0", conv[0], 1'b0);
                check_eq("hold_pend1", pend[1], 1'b1);
            end
            cycle();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            #1;
            check_eq($sformatf("drain_rdy0_%0d", j), rdy[0], j >= 1);
            check_eq($sformatf("drain_rdy1_%0d", j), rdy[1], j >= 3);
            check_eq($sformatf("drain_conv1_%0d", j), conv[1], j >= 3);
            cycle();
        end
        check_eq("f1_conv0", conv[0], 1'b1);
        check_eq("f1_fcnt1", fcnt[1], 16'd1);

        // Frame 2, converting; two requests, last one (disable) wins.
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, k == 0, (k == 2) || (k == 5), k == 2);
            #1;
            if (k == 4) check_eq("eol_dly0", eol_o[0], 1'b1);
            if (k == 6) check_eq("eol_dly1", eol_o[1], 1'b1);
            cycle();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) cycle();
        check_eq("last_wins_conv0", conv[0], 1'b0);
        check_eq("last_wins_conv1", conv[1], 1'b0);
        check_eq("f2_fcnt0", fcnt[0], 16'd2);

        // Frame 3: spurious SOF at (2,1), then a clean full frame from that point.
        for (int k = 0; k < 7; k++) begin
            set_in(1'b1, (k == 0) || (k == 6), 1'b0, 1'b0);
            cycle();
        end
        check_eq("sync_err0", err[0], 1'b1);
        check_eq("sync_err_fcnt1", fcnt[1], 16'd2);
        for (int k = 0; k < 7; k++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        check_eq("resync_fcnt0", fcnt[0], 16'd3);
        check_eq("resync_err1", err[1], 1'b1);
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_eq("err_clear0", err[0], 1'b0);
        check_eq("err_clear_pend1", pend[1], 1'b1);

        // Frame 4 ends in a drain; reset lands in the middle of it.
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, k == 0, 1'b0, 1'b0);
            cycle();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("pre_rst_rdy1", rdy[1], 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("drain_rst");
        cycle();
        cycle();
        rst_n = 1'b1;

        // Request before the first SOF applies without a stall.
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        cycle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_eq("pre_sof_conv0", conv[0], 1'b1);
        check_eq("pre_sof_pend1", pend[1], 1'b0);
        check_eq("pre_sof_rdy1", rdy[1], 1'b1);

        // Randomized traffic, continuous-ish valid, occasional spurious SOF and requests.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                vld[i] = ($urandom_range(0, 9) < 8);
                if (!m_sync[i] || m_idx[i] == 0) sof[i] = ($urandom_range(0, 5) != 0);
                else sof[i] = ($urandom_range(0, 39) == 0);
            end
            cfg_up = ($urandom_range(0, 24) == 0);
            cfg_en = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
